// File: rtl/udp128_tx_serializer_if.sv
// udp128 descriptor/word bus between the DPB command master and the UDP payload serializer.
interface udp128_tx_serializer_if;
    logic         en;
    logic [127:0] ddr3_udp_wrdata;
    logic         udp_last_frame_flag;
    logic [14:0]  mjpeg_frame_rank;
    logic [15:0]  udp_jpeg_len;
    logic [15:0]  udp_ipv4_sign;
    logic         ddr3_data_upd_req;
    logic         udp_frame_down;
    logic         busy;

    modport master (
        output en, ddr3_udp_wrdata, udp_last_frame_flag, mjpeg_frame_rank,
               udp_jpeg_len, udp_ipv4_sign,
        input  ddr3_data_upd_req, udp_frame_down, busy
    );

    modport slave (
        input  en, ddr3_udp_wrdata, udp_last_frame_flag, mjpeg_frame_rank,
               udp_jpeg_len, udp_ipv4_sign,
        output ddr3_data_upd_req, udp_frame_down, busy
    );
endinterface

// File: rtl/udp128_tx_serializer.sv
// Serialises a 4-byte application header plus up to MAX_PAYLOAD payload bytes, pulling
// follow-on 128-bit words from the command master one request at a time.
module udp128_tx_serializer #(
    parameter int REQ_LAT     = 2,
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic                  i_pclk,
    input  logic                  i_rst_n,
    udp128_tx_serializer_if.slave udp128,
    output logic                  o_tx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_sop,
    output logic                  o_tx_eop,
    input  logic                  i_tx_ready,
    output logic [15:0]           o_ipv4_id,
    output logic                  o_len_err
);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [2:0]  LAT_LAST = 3'(REQ_LAT);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, WAIT_WORD, DONE} state_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [127:0] word, input logic [3:0] idx);
        return word[{~idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic last,
                                            input logic [14:0] rank, input logic [15:0] len);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0: b = {last, rank[14:8]};
            2'd1: b = rank[7:0];
            2'd2: b = len[15:8];
            2'd3: b = len[7:0];
        endcase
        return b;
    endfunction

    state_t       state;
    logic [127:0] word_q;
    logic [15:0]  len_q;
    logic [15:0]  remaining;
    logic [14:0]  rank_q;
    logic         last_q;
    logic [1:0]   hdr_cnt;
    logic [3:0]   byte_idx;
    logic [2:0]   lat_cnt;
    logic         upd_req_q;
    logic         frame_down_q;
    logic         busy_q;
    logic [15:0]  in_len;
    logic         accept;

    assign in_len = clamp_len(udp128.udp_jpeg_len);
    assign accept = o_tx_valid & i_tx_ready;

    assign udp128.ddr3_data_upd_req = upd_req_q;
    assign udp128.udp_frame_down    = frame_down_q;
    assign udp128.busy              = busy_q;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            word_q       <= '0;
            len_q        <= '0;
            remaining    <= '0;
            rank_q       <= '0;
            last_q       <= 1'b0;
            hdr_cnt      <= '0;
            byte_idx     <= '0;
            lat_cnt      <= '0;
            upd_req_q    <= 1'b0;
            frame_down_q <= 1'b0;
            busy_q       <= 1'b0;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            o_tx_sop     <= 1'b0;
            o_tx_eop     <= 1'b0;
            o_ipv4_id    <= '0;
            o_len_err    <= 1'b0;
        end else begin
            upd_req_q    <= 1'b0;
            frame_down_q <= 1'b0;
            o_len_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (udp128.en) begin
                        word_q     <= udp128.ddr3_udp_wrdata;
                        len_q      <= in_len;
                        rank_q     <= udp128.mjpeg_frame_rank;
                        last_q     <= udp128.udp_last_frame_flag;
                        o_ipv4_id  <= udp128.udp_ipv4_sign;
                        o_len_err  <= (udp128.udp_jpeg_len > MAX_LEN);
                        busy_q     <= 1'b1;
                        hdr_cnt    <= 2'd0;
                        o_tx_valid <= 1'b1;
                        o_tx_sop   <= 1'b1;
                        o_tx_eop   <= 1'b0;
                        o_tx_data  <= {udp128.udp_last_frame_flag, udp128.mjpeg_frame_rank[14:8]};
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        o_tx_sop <= 1'b0;
                        if (hdr_cnt == 2'd3) begin
                            if (len_q == 16'd0) begin
                                o_tx_valid   <= 1'b0;
                                o_tx_eop     <= 1'b0;
                                frame_down_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state        <= DONE;
                            end else begin
                                byte_idx  <= 4'd0;
                                remaining <= len_q;
                                o_tx_data <= pick_byte(word_q, 4'd0);
                                o_tx_eop  <= (len_q == 16'd1);
                                state     <= PAYLOAD;
                            end
                        end else begin
                            hdr_cnt   <= hdr_cnt + 2'd1;
                            o_tx_data <= hdr_byte(hdr_cnt + 2'd1, last_q, rank_q, len_q);
                            o_tx_eop  <= (hdr_cnt == 2'd2) && (len_q == 16'd0);
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            o_tx_valid   <= 1'b0;
                            o_tx_eop     <= 1'b0;
                            frame_down_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state        <= DONE;
                        end else if (byte_idx == 4'd15) begin
                            // Word exhausted with bytes still owed: fetch the next one.
                            o_tx_valid <= 1'b0;
                            upd_req_q  <= 1'b1;
                            lat_cnt    <= 3'd0;
                            state      <= WAIT_WORD;
                        end else begin
                            byte_idx  <= byte_idx + 4'd1;
                            o_tx_data <= pick_byte(word_q, byte_idx + 4'd1);
                            o_tx_eop  <= (remaining == 16'd2);
                        end
                    end
                end
                WAIT_WORD: begin
                    // lat_cnt equals REQ_LAT in the cycle the master presents the new word.
                    if (lat_cnt == LAT_LAST) begin
                        word_q     <= udp128.ddr3_udp_wrdata;
                        byte_idx   <= 4'd0;
                        o_tx_data  <= pick_byte(udp128.ddr3_udp_wrdata, 4'd0);
                        o_tx_eop   <= (remaining == 16'd1);
                        o_tx_valid <= 1'b1;
                        state      <= PAYLOAD;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp128_tx_serializer.sv
// Directed bench for udp128_tx_serializer: header/payload byte streams, requests,
// stalls, length clamp and mid-packet reset.
module tb_udp128_tx_serializer;
    localparam int REQ_LAT     = 2;
    localparam int MAX_PAYLOAD = 1024;
    localparam logic [127:0] POISON = {16{8'hA5}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid, tx_sop, tx_eop, tx_ready, len_err;
    logic [7:0]  tx_data;
    logic [15:0] ipv4_id;

    udp128_tx_serializer_if bus();

    udp128_tx_serializer #(.REQ_LAT(REQ_LAT), .MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .i_pclk     (clk),
        .i_rst_n    (rst_n),
        .udp128     (bus),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .o_tx_sop   (tx_sop),
        .o_tx_eop   (tx_eop),
        .i_tx_ready (tx_ready),
        .o_ipv4_id  (ipv4_id),
        .o_len_err  (len_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] seed = 8'h00;
    logic       first_valid = 1'b0;
    logic       req_valid = 1'b0;
    int         req_idx = 0;
    logic       ready_mode = 1'b0;

    logic [7:0] cap_data[$];
    logic       cap_sop[$];
    logic       cap_eop[$];
    logic [7:0] exp_q[$];
    int n_req = 0, n_fd = 0, n_lenerr = 0, stall_err = 0;
    int cyc = 0, sop_cyc = 0, eop_cyc = 0, fd_cyc = 0;
    logic fd_busy = 1'b0;
    logic stall_prev = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Word k of a packet carries bytes seed+16k .. seed+16k+15, so payload byte n is seed+n.
    function automatic logic [127:0] word_gen(input logic [7:0] sd, input int k);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) w[127-8*j -: 8] = sd + 8'(16*k + j);
        return w;
    endfunction

    assign bus.ddr3_udp_wrdata = first_valid ? word_gen(seed, 0) :
                                 req_valid   ? word_gen(seed, req_idx) : POISON;

    // Command master: presents the requested word exactly REQ_LAT cycles after the pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy !== 1'b1) req_idx = 0;
            else if (bus.ddr3_data_upd_req === 1'b1) begin
                req_idx = req_idx + 1;
                repeat (REQ_LAT) @(posedge clk);
                #1 req_valid = 1'b1;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 tx_ready = ready_mode ? ~tx_ready : 1'b1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            cap_data.push_back(tx_data);
            cap_sop.push_back(tx_sop);
            cap_eop.push_back(tx_eop);
            if (tx_sop) sop_cyc <= cyc;
            if (tx_eop) eop_cyc <= cyc;
        end
        if (bus.ddr3_data_upd_req === 1'b1) n_req <= n_req + 1;
        if (bus.udp_frame_down === 1'b1) begin
            n_fd    <= n_fd + 1;
            fd_cyc  <= cyc;
            fd_busy <= bus.busy;
        end
        if (len_err === 1'b1) n_lenerr <= n_lenerr + 1;
        if (stall_prev && !(tx_valid && tx_data === prev_data && tx_sop === prev_sop
                            && tx_eop === prev_eop))
            stall_err <= stall_err + 1;
        stall_prev <= tx_valid && !tx_ready;
        prev_data  <= tx_data;
        prev_sop   <= tx_sop;
        prev_eop   <= tx_eop;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic build_exp(input logic [15:0] hlen, input logic [14:0] rk, input logic lf,
                             input logic [7:0] sd, input int npay);
        logic [7:0] b;
        exp_q.delete();
        b = {lf, rk[14:8]};
        exp_q.push_back(b);
        exp_q.push_back(rk[7:0]);
        exp_q.push_back(hlen[15:8]);
        exp_q.push_back(hlen[7:0]);
        for (int i = 0; i < npay; i++) exp_q.push_back(sd + 8'(i));
    endtask

    // Mismatches against exp_q, including sop only on the first and eop only on the last byte.
    function automatic int seq_mis(input int b);
        int m;
        m = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b + i >= cap_data.size()) m++;
            else if (cap_data[b+i] !== exp_q[i] || cap_sop[b+i] !== (i == 0) ||
                     cap_eop[b+i] !== (i == exp_q.size() - 1)) m++;
        end
        return m;
    endfunction

    task automatic start_pkt(input logic [15:0] jl, input logic [14:0] rk, input logic lf,
                             input logic [15:0] sg, input logic [7:0] sd);
        @(posedge clk);
        #1;
        seed                    = sd;
        first_valid             = 1'b1;
        bus.udp_jpeg_len        = jl;
        bus.mjpeg_frame_rank    = rk;
        bus.udp_last_frame_flag = lf;
        bus.udp_ipv4_sign       = sg;
        bus.en                  = 1'b1;
        @(posedge clk);
        #1;
        bus.en      = 1'b0;
        first_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({tx_valid, tx_sop, tx_eop, tx_data, ipv4_id, len_err, bus.busy,
             bus.ddr3_data_upd_req, bus.udp_frame_down} !== 31'd0) begin
            bad++;
            $display("FAIL reset_outputs: got nonzero outputs while in reset, want all 0");
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_valid, bus.busy, bus.ddr3_data_upd_req, bus.udp_frame_down} !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_reset: valid/busy/req/fd=%b want 0000",
                     {tx_valid, bus.busy, bus.ddr3_data_upd_req, bus.udp_frame_down});
        end
    endtask

    task automatic test_basic();
        int b, r0, f0, l0, m;
        b = cap_data.size(); r0 = n_req; f0 = n_fd; l0 = n_lenerr;
        build_exp(16'd20, 15'd5, 1'b0, 8'h10, 20);
        start_pkt(16'd20, 15'd5, 1'b0, 16'hBEEF, 8'h10);
        @(negedge clk);
        total++;
        if ({bus.busy, tx_valid, tx_sop, tx_data} !== {3'b111, 8'h00}) begin
            bad++;
            $display("FAIL basic_first_cycle: busy/valid/sop/data=%b want 11100000000",
                     {bus.busy, tx_valid, tx_sop, tx_data});
        end
        total++;
        if (ipv4_id !== 16'hBEEF) begin
            bad++;
            $display("FAIL basic_ipv4_id: got %h want beef", ipv4_id);
        end
        for (int i = 0; i < 200 && n_fd == f0; i++) begin @(negedge clk); #1; end
        total++;
        if (n_fd - f0 !== 1) begin
            bad++;
            $display("FAIL basic_frame_down: got %0d pulses want 1", n_fd - f0);
        end
        m = seq_mis(b);
        total++;
        if (cap_data.size() - b !== 24 || m !== 0) begin
            bad++;
            $display("FAIL basic_bytes: got %0d bytes/%0d mismatches want 24/0",
                     cap_data.size() - b, m);
        end
        total++;
        if (n_req - r0 !== 1) begin
            bad++;
            $display("FAIL basic_req_count: got %0d want 1", n_req - r0);
        end
        total++;
        if (eop_cyc - sop_cyc !== 26) begin
            bad++;
            $display("FAIL basic_throughput: sop-to-eop %0d cycles want 26", eop_cyc - sop_cyc);
        end
        total++;
        if (fd_cyc !== eop_cyc + 1 || fd_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_fd_timing: fd-eop=%0d busy=%b want 1 0", fd_cyc - eop_cyc, fd_busy);
        end
        total++;
        if (n_lenerr - l0 !== 0) begin
            bad++;
            $display("FAIL basic_len_err: got %0d pulses want 0", n_lenerr - l0);
        end
    endtask

    task automatic test_zero_len();
        int b, r0, f0, m;
        b = cap_data.size(); r0 = n_req; f0 = n_fd;
        build_exp(16'd0, 15'h7FFF, 1'b1, 8'h00, 0);
        start_pkt(16'd0, 15'h7FFF, 1'b1, 16'h1234, 8'h00);
        for (int i = 0; i < 50 && n_fd == f0; i++) begin @(negedge clk); #1; end
        total++;
        if (n_fd - f0 !== 1) begin
            bad++;
            $display("FAIL zero_frame_down: got %0d pulses want 1", n_fd - f0);
        end
        m = seq_mis(b);
        total++;
        if (cap_data.size() - b !== 4 || m !== 0) begin
            bad++;
            $display("FAIL zero_bytes: got %0d bytes/%0d mismatches want 4/0 (FF FF 00 00)",
                     cap_data.size() - b, m);
        end
        total++;
        if (n_req - r0 !== 0) begin
            bad++;
            $display("FAIL zero_req_count: got %0d want 0", n_req - r0);
        end
    endtask

    task automatic test_len16();
        int b, r0, f0, m;
        b = cap_data.size(); r0 = n_req; f0 = n_fd;
        build_exp(16'd16, 15'h0123, 1'b0, 8'hF8, 16);
        start_pkt(16'd16, 15'h0123, 1'b0, 16'h0042, 8'hF8);
        repeat (6) @(posedge clk);
        // A stray en mid-packet must be ignored.
        #1 bus.en = 1'b1; bus.udp_jpeg_len = 16'd5;
        @(posedge clk);
        #1 bus.en = 1'b0;
        for (int i = 0; i < 100 && n_fd == f0; i++) begin @(negedge clk); #1; end
        total++;
        if (n_fd - f0 !== 1) begin
            bad++;
            $display("FAIL len16_frame_down: got %0d pulses want 1", n_fd - f0);
        end
        m = seq_mis(b);
        total++;
        if (cap_data.size() - b !== 20 || m !== 0) begin
            bad++;
            $display("FAIL len16_bytes: got %0d bytes/%0d mismatches want 20/0",
                     cap_data.size() - b, m);
        end
        total++;
        if (n_req - r0 !== 0) begin
            bad++;
            $display("FAIL len16_req_count: got %0d want 0", n_req - r0);
        end
    endtask

    task automatic test_stall();
        int b, r0, f0, s0, m;
        b = cap_data.size(); r0 = n_req; f0 = n_fd; s0 = stall_err;
        build_exp(16'd20, 15'd5, 1'b0, 8'h10, 20);
        ready_mode = 1'b1;
        start_pkt(16'd20, 15'd5, 1'b0, 16'hBEEF, 8'h10);
        for (int i = 0; i < 300 && n_fd == f0; i++) begin @(negedge clk); #1; end
        ready_mode = 1'b0;
        total++;
        if (n_fd - f0 !== 1) begin
            bad++;
            $display("FAIL stall_frame_down: got %0d pulses want 1", n_fd - f0);
        end
        m = seq_mis(b);
        total++;
        if (cap_data.size() - b !== 24 || m !== 0) begin
            bad++;
            $display("FAIL stall_bytes: got %0d bytes/%0d mismatches want 24/0",
                     cap_data.size() - b, m);
        end
        total++;
        if (stall_err - s0 !== 0) begin
            bad++;
            $display("FAIL stall_hold: %0d stalls changed data/flags want 0", stall_err - s0);
        end
        total++;
        if (n_req - r0 !== 1) begin
            bad++;
            $display("FAIL stall_req_count: got %0d want 1", n_req - r0);
        end
    endtask

    task automatic test_clamp();
        int b, r0, f0, l0, m;
        b = cap_data.size(); r0 = n_req; f0 = n_fd; l0 = n_lenerr;
        build_exp(16'd1024, 15'd77, 1'b0, 8'h80, 1024);
        start_pkt(16'd2000, 15'd77, 1'b0, 16'h5A5A, 8'h80);
        @(negedge clk);
        total++;
        if (len_err !== 1'b1) begin
            bad++;
            $display("FAIL clamp_len_err_timing: got %b want 1", len_err);
        end
        for (int i = 0; i < 3000 && n_fd == f0; i++) begin @(negedge clk); #1; end
        total++;
        if (n_fd - f0 !== 1) begin
            bad++;
            $display("FAIL clamp_frame_down: got %0d pulses want 1", n_fd - f0);
        end
        total++;
        if (cap_data.size() - b < 4 || cap_data[b+2] !== 8'h04 || cap_data[b+3] !== 8'h00) begin
            bad++;
            $display("FAIL clamp_hdr_len: header length bytes wrong, want 04 00");
        end
        m = seq_mis(b);
        total++;
        if (cap_data.size() - b !== 1028 || m !== 0) begin
            bad++;
            $display("FAIL clamp_bytes: got %0d bytes/%0d mismatches want 1028/0",
                     cap_data.size() - b, m);
        end
        total++;
        if (n_req - r0 !== 63) begin
            bad++;
            $display("FAIL clamp_req_count: got %0d want 63", n_req - r0);
        end
        total++;
        if (n_lenerr - l0 !== 1) begin
            bad++;
            $display("FAIL clamp_len_err_count: got %0d want 1", n_lenerr - l0);
        end
    endtask

    task automatic test_reset_midpacket();
        int b, r0, f0, m;
        b = cap_data.size();
        start_pkt(16'd40, 15'd3, 1'b0, 16'hCAFE, 8'h33);
        for (int i = 0; i < 100 && cap_data.size() - b < 12; i++) begin @(negedge clk); #1; end
        @(posedge clk);
        #1 rst_n = 1'b0;
        r0 = n_req; f0 = n_fd;
        #1;
        total++;
        if ({tx_valid, tx_sop, tx_eop, tx_data, ipv4_id, len_err, bus.busy,
             bus.ddr3_data_upd_req, bus.udp_frame_down} !== 31'd0) begin
            bad++;
            $display("FAIL midreset_outputs: outputs nonzero during reset, want all 0");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        total++;
        if (n_fd - f0 !== 0 || n_req - r0 !== 0) begin
            bad++;
            $display("FAIL midreset_no_fd: got fd=%0d req=%0d want 0 0", n_fd - f0, n_req - r0);
        end
        b = cap_data.size(); r0 = n_req; f0 = n_fd;
        build_exp(16'd20, 15'd9, 1'b1, 8'h44, 20);
        start_pkt(16'd20, 15'd9, 1'b1, 16'h0777, 8'h44);
        for (int i = 0; i < 200 && n_fd == f0; i++) begin @(negedge clk); #1; end
        m = seq_mis(b);
        total++;
        if (n_fd - f0 !== 1 || cap_data.size() - b !== 24 || m !== 0) begin
            bad++;
            $display("FAIL midreset_recover: fd=%0d bytes=%0d mis=%0d want 1 24 0",
                     n_fd - f0, cap_data.size() - b, m);
        end
        total++;
        if (n_req - r0 !== 1) begin
            bad++;
            $display("FAIL midreset_req_count: got %0d want 1", n_req - r0);
        end
    endtask

    initial begin
        bus.en                  = 1'b0;
        bus.udp_jpeg_len        = 16'd0;
        bus.mjpeg_frame_rank    = 15'd0;
        bus.udp_last_frame_flag = 1'b0;
        bus.udp_ipv4_sign       = 16'd0;
        test_reset();
        test_basic();
        test_zero_len();
        test_len16();
        test_stall();
        test_clamp();
        test_reset_midpacket();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
